// File: rtl/change_payout_ctrl_pkg.sv
// Shared vending types: payout FSM states,
// completion status codes and coin values.
package change_payout_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SELECT,
    S_EJECT,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_SHORT   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam int COIN_HI = 2;
  localparam int COIN_LO = 1;

endpackage

// File: rtl/change_payout_ctrl_inv_counter.sv
// Saturating coin inventory counter: adds refill, subtracts one
// committed coin. Ports: clk, reset, refill_valid, refill, dec, count.
module inv_counter #(
  parameter int W = 6,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         refill_valid,
  input  logic [W-1:0] refill,
  input  logic         dec,
  output logic [W-1:0] count
);

  localparam logic [W:0] MAX = {1'b0, {W{1'b1}}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W:0]   sum;
  logic [W:0]   net;

  // One extra bit holds inv + refill before clamping.
  always_comb begin
    sum = {1'b0, count_q};
    if (refill_valid) begin
      sum = sum + {1'b0, refill};
    end
    net = sum;
    if (dec) begin
      net = (sum == '0) ? '0 : sum - 1'b1;
    end
    if (net > MAX) begin
      count_d = MAX[W-1:0];
    end else begin
      count_d = net[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= INIT;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/change_payout_ctrl.sv
// Change payout sequencer: checks inventory, then ejects coins one
// at a time (2-unit first) with a per-coin ack timeout.
// Ports: req_* from sale FSM, hop*_pulse/hop_done to hopper,
// refill_*, done_* completion, inv*_count, busy.
module change_payout_ctrl
  import change_payout_ctrl_pkg::*;
#(
  parameter int AMT_W       = 4,
  parameter int INV_W       = 6,
  parameter int HOP_TIMEOUT = 15,
  parameter int INIT_INV2   = 8,
  parameter int INIT_INV1   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             hop2_pulse,
  output logic             hop1_pulse,
  input  logic             hop_done,
  input  logic             refill_valid,
  input  logic [INV_W-1:0] refill2,
  input  logic [INV_W-1:0] refill1,
  output logic             done_valid,
  output logic [1:0]       done_status,
  output logic [AMT_W-1:0] paid_amount,
  output logic [INV_W-1:0] inv2_count,
  output logic [INV_W-1:0] inv1_count,
  output logic             busy
);

  localparam int TW = $clog2(HOP_TIMEOUT + 1);
  localparam int MW = (AMT_W > INV_W) ? AMT_W : INV_W;
  localparam int CW = MW + 2;

  state_e           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] paid_q, paid_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             sel_hi_q, sel_hi_d;
  logic             hop2_q, hop2_d;
  logic             hop1_q, hop1_d;
  logic             done_q, done_d;
  logic [1:0]       status_q, status_d;
  logic [AMT_W-1:0] pout_q, pout_d;

  logic [CW-1:0]    half;
  logic [CW-1:0]    inv2_w;
  logic [CW-1:0]    n2;
  logic [CW-1:0]    need1;
  logic [AMT_W-1:0] coin;

  inv_counter #(
    .W    (INV_W),
    .INIT (INV_W'(INIT_INV2))
  ) u_inv2 (
    .clk          (clk),
    .reset        (reset),
    .refill_valid (refill_valid),
    .refill       (refill2),
    .dec          (hop2_q),
    .count        (inv2_count)
  );

  inv_counter #(
    .W    (INV_W),
    .INIT (INV_W'(INIT_INV1))
  ) u_inv1 (
    .clk          (clk),
    .reset        (reset),
    .refill_valid (refill_valid),
    .refill       (refill1),
    .dec          (hop1_q),
    .count        (inv1_count)
  );

  // Feasibility: greedy 2-unit count, remainder must fit in 1s.
  always_comb begin
    half   = CW'(rem_q >> 1);
    inv2_w = CW'(inv2_count);
    n2     = (half < inv2_w) ? half : inv2_w;
    need1  = CW'(rem_q) - (n2 << 1);
  end

  assign coin = sel_hi_q ? AMT_W'(COIN_HI) : AMT_W'(COIN_LO);

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    paid_d   = paid_q;
    timer_d  = timer_q;
    sel_hi_d = sel_hi_q;
    status_d = status_q;
    pout_d   = pout_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rem_d   = req_amount;
          paid_d  = '0;
          timer_d = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (need1 > CW'(inv1_count)) begin
          status_d = ST_SHORT;
          pout_d   = '0;
          state_d  = S_DONE;
        end else begin
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (rem_q == '0) begin
          status_d = ST_OK;
          pout_d   = paid_q;
          state_d  = S_DONE;
        end else begin
          sel_hi_d = (rem_q >= AMT_W'(COIN_HI))
                   && (inv2_count != '0);
          state_d  = S_EJECT;
        end
      end
      S_EJECT: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (hop_done) begin
          rem_d   = rem_q - coin;
          paid_d  = paid_q + coin;
          state_d = S_SELECT;
        end else if (timer_q == TW'(HOP_TIMEOUT - 1)) begin
          status_d = ST_TIMEOUT;
          pout_d   = paid_q;
          state_d  = S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Pulses are registered so they line up with EJECT/DONE.
    hop2_d = (state_d == S_EJECT) && sel_hi_d;
    hop1_d = (state_d == S_EJECT) && !sel_hi_d;
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      paid_q   <= '0;
      timer_q  <= '0;
      sel_hi_q <= 1'b0;
      hop2_q   <= 1'b0;
      hop1_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= ST_OK;
      pout_q   <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      paid_q   <= paid_d;
      timer_q  <= timer_d;
      sel_hi_q <= sel_hi_d;
      hop2_q   <= hop2_d;
      hop1_q   <= hop1_d;
      done_q   <= done_d;
      status_q <= status_d;
      pout_q   <= pout_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign hop2_pulse  = hop2_q;
  assign hop1_pulse  = hop1_q;
  assign done_valid  = done_q;
  assign done_status = status_q;
  assign paid_amount = pout_q;

endmodule

// File: doc/change_payout_ctrl.md
# change_payout_ctrl

Controller that sequences the vending machine's coin hopper to pay out change after a sale. It accepts a change amount from the sale FSM and checks that the request can be met from the current 2-unit and 1-unit coin inventories. It then drives one hopper eject pulse at a time, greedy with 2-unit coins first, and waits for each coin's acknowledge with a timeout. It sits between the purchase/credit FSM and the physical hopper, and keeps the coin inventory counts.

## Interface
- AMT_W, 4: width of change amount and paid count
- INV_W, 6: width of each inventory counter
- HOP_TIMEOUT, 15: cycles to wait for hop_done before aborting
- INIT_INV2, 8: 2-unit coin inventory after reset
- INIT_INV1, 8: 1-unit coin inventory after reset

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  change request present
- req_amount  in  AMT_W  change to pay, in units
- req_ready  out  1  controller idle and able to accept
- hop2_pulse  out  1  one-cycle eject command, 2-unit coin
- hop1_pulse  out  1  one-cycle eject command, 1-unit coin
- hop_done  in  1  hopper acknowledge, one coin ejected
- refill_valid  in  1  add refill counts this cycle
- refill2  in  INV_W  2-unit coins added
- refill1  in  INV_W  1-unit coins added
- done_valid  out  1  one-cycle completion pulse
- done_status  out  2  00 OK, 01 SHORT, 10 TIMEOUT
- paid_amount  out  AMT_W  units actually acknowledged by hopper
- inv2_count  out  INV_W  current 2-unit inventory
- inv1_count  out  INV_W  current 1-unit inventory
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CHECK, SELECT, EJECT, WAIT, DONE.
- IDLE: req_ready = 1, combinational from state. A request is accepted when req_valid && req_ready. On accept, latch rem = req_amount, clear paid and timer, go to CHECK.
- CHECK (one cycle): n2 = min(rem>>1, inv2); need1 = rem - 2*n2.
  - need1 > inv1: status SHORT, no coins ejected, paid 0, go to DONE.
  - Otherwise go to SELECT.
- SELECT:
  - rem == 0: status OK, go to DONE.
  - rem >= 2 and inv2 > 0: coin_sel = 2, go to EJECT.
  - Otherwise: coin_sel = 1, go to EJECT.
- EJECT (one cycle):
  - Assert hop2_pulse or hop1_pulse per coin_sel.
  - Decrement the matching inventory, since the coin is committed.
  - Clear timer, go to WAIT.
- WAIT:
  - hop_done: rem -= coin_sel, paid += coin_sel, go to SELECT.
  - Otherwise timer++. When timer == HOP_TIMEOUT-1 without hop_done: status TIMEOUT, go to DONE.
- DONE: done_valid = 1 for one cycle. done_status and paid_amount are valid that cycle and hold until the next accept. Then go to IDLE.
- hop_done outside WAIT is ignored.
- Refill is applied in any state. Each counter becomes inv + refill - (decrement this cycle), saturating at 2^INV_W-1 and never below 0.
- Inventory arithmetic uses INV_W+1 bits internally before saturation.

## Timing
- Reset values:
  - State IDLE, req_ready 1, busy 0.
  - hop2_pulse, hop1_pulse, done_valid 0.
  - done_status 00, paid_amount 0.
  - inv2_count INIT_INV2, inv1_count INIT_INV1.
- req_amount = 0: accept at cycle t, CHECK t+1, SELECT t+2, done_valid at t+3, status OK.
- Per coin: SELECT, EJECT, then WAIT of at least one cycle. Minimum 3 cycles per coin when hop_done arrives the cycle after the pulse.
- Pulses are never asserted back to back; at most one pulse is outstanding.
- Reset mid-operation aborts immediately. No done pulse is produced. Inventories return to their INIT values.

## Structure
- Shared vending package: state enum, done_status codes (ST_OK, ST_SHORT, ST_TIMEOUT), coin value constants (COIN_HI = 2, COIN_LO = 1).
- One sub-module, inv_counter (saturating up/down counter with refill). Instantiated twice.

## Test plan
- INIT 4/4, request 5 -> pulse sequence 2, 2, 1 with immediate acks. done OK, paid 5, inv2 = 2, inv1 = 3.
- inv2 = 0, inv1 = 4, request 7 -> no pulses. done SHORT, paid 0, inventories unchanged.
- Request 3, no hop_done after the first hop2_pulse -> done TIMEOUT exactly HOP_TIMEOUT cycles after entering WAIT. paid 0, inv2 decremented by 1.
- Request 0 -> done_valid 3 cycles after accept, status OK, no pulses.
- inv1 = 62 (INV_W 6), refill1 = 5 in the same cycle as a hop1_pulse decrement -> inv1 = 63 (saturated).
- Reset asserted during WAIT -> outputs return to reset values immediately. A later request 2 completes OK with paid 2.
